// File: rtl/io_pkg.sv
// Shared definitions for the switch/LED board I/O stage.
// Provides the per-bit debounce state encoding and default sizing for the
// debounce counter. Imported by debounce_bit and sw_led_io_ctrl.
package io_pkg;

  // Debounce FSM encoding. Bit 1 doubles as the debounced level.
  localparam logic [1:0] ST_LO   = 2'd0;
  localparam logic [1:0] PEND_HI = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] PEND_LO = 2'd3;

  localparam int unsigned DEB_CYCLES_DEF = 50000;
  localparam int unsigned CNT_W_DEF      = 16;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer operating on an already-synchronised input.
// A new level is accepted only after DEB_CYCLES consecutive samples agree;
// any reversal while pending returns to the previous stable state.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   d_sync  synchronised input sample
//   level   debounced level
//   rise    one-cycle pulse on an accepted 0->1 change
//   fall    one-cycle pulse on an accepted 1->0 change
module debounce_bit
  import io_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_sync,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LO: begin
        if (d_sync) begin
          state_d = PEND_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      PEND_HI: begin
        if (!d_sync) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          // The DEB_CYCLES-th agreeing sample commits the new level.
          state_d = ST_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!d_sync) begin
          state_d = PEND_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      PEND_LO: begin
        if (d_sync) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = ST_LO;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Level is 1 in ST_HI and PEND_LO, i.e. bit 1 of the encoding.
  assign level = state_q[1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/sw_led_io_ctrl.sv
// Board-side I/O stage around the processor's SW input and LEDS output.
// Raw switches are 2-flop synchronised and debounced per bit, producing clean
// levels, one-cycle edge pulses and sticky event flags. The LED byte is
// registered before the pads.
// Optional feature macro LED_PWM_EN: adds pwm_duty and a free-running 8-bit
// counter that gates the LED pads (registered compare, LED latency 2 cycles).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   sw_raw      raw asynchronous switch pins
//   sw_clean    debounced switch levels
//   sw_rise     per-bit pulse on debounced 0->1
//   sw_fall     per-bit pulse on debounced 1->0
//   evt_flag    sticky per-bit edge flags
//   evt_clr     per-bit flag clear
//   led_in      LED byte from the processor
//   led_pad     registered LED pad drive
//   pwm_duty    LED brightness duty (LED_PWM_EN only)
module sw_led_io_ctrl
  import io_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] evt_flag,
  input  logic [WIDTH-1:0] evt_clr,
  input  logic [WIDTH-1:0] led_in,
`ifdef LED_PWM_EN
  input  logic [7:0]       pwm_duty,
`endif
  output logic [WIDTH-1:0] led_pad
);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] evt_flag_q, evt_flag_d;
  logic [WIDTH-1:0] led_pad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .d_sync(s2_q[i]),
      .level (sw_clean[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  // Set has priority over clear so an edge is never lost.
  always_comb begin
    evt_flag_d = (evt_flag_q & ~evt_clr) | sw_rise | sw_fall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_flag_q <= '0;
    end else begin
      evt_flag_q <= evt_flag_d;
    end
  end

  assign evt_flag = evt_flag_q;

`ifdef LED_PWM_EN
  logic [7:0]       pwm_cnt_q;
  logic             pwm_on_q;
  logic [WIDTH-1:0] led_reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pwm_on_q  <= 1'b0;
      led_reg_q <= '0;
      led_pad_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_on_q  <= (pwm_cnt_q < pwm_duty);
      led_reg_q <= led_in;
      led_pad_q <= led_reg_q & {WIDTH{pwm_on_q}};
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_pad_q <= '0;
    end else begin
      led_pad_q <= led_in;
    end
  end
`endif

  assign led_pad = led_pad_q;

endmodule

// File: tb/tb_sw_led_io_ctrl.sv
// Self-checking bench for sw_led_io_ctrl with DEB_CYCLES=4.
// Reference model: a debounced level flips once the synchronised input has
// disagreed with it for DEB consecutive cycles; flags and LEDs are modelled
// from their cycle-level rules.
module tb_sw_led_io_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned DEB = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic [W-1:0] evt_flag;
  logic [W-1:0] evt_clr;
  logic [W-1:0] led_in;
  logic [W-1:0] led_pad;
  logic [7:0]   pwm_duty;

  sw_led_io_ctrl #(
    .WIDTH     (W),
    .DEB_CYCLES(DEB),
    .CNT_W     (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .evt_flag(evt_flag),
    .evt_clr (evt_clr),
    .led_in  (led_in),
`ifdef LED_PWM_EN
    .pwm_duty(pwm_duty),
`endif
    .led_pad (led_pad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [W-1:0] m_d1, m_d2;   // raw input delayed by one and two edges
  logic [W-1:0] m_lvl, m_rise, m_fall, m_flag, m_pad;
  int           m_run [W];    // consecutive cycles synced input != level
  logic [W-1:0] m_led1;
  logic         m_on1;
  int           m_edges;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
    m_flag = '0; m_pad = '0; m_led1 = '0; m_on1 = 1'b0; m_edges = 0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw, input logic [W-1:0] clr,
                            input logic [W-1:0] led);
    logic [W-1:0] nr, nf;
    m_flag = (m_flag & ~clr) | m_rise | m_fall;
    nr = '0;
    nf = '0;
    for (int i = 0; i < W; i++) begin
      if (m_d2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) nr[i] = 1'b1;
          else nf[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_rise = nr;
    m_fall = nf;
    m_d2 = m_d1;
    m_d1 = raw;
`ifdef LED_PWM_EN
    m_pad  = m_led1 & {W{m_on1}};
    m_on1  = ((m_edges % 256) < int'(pwm_duty));
    m_led1 = led;
`else
    m_pad = led;
`endif
    m_edges++;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sw_clean", sw_clean, m_lvl);
    chk("sw_rise", sw_rise, m_rise);
    chk("sw_fall", sw_fall, m_fall);
    chk("evt_flag", evt_flag, m_flag);
    chk("led_pad", led_pad, m_pad);
  endtask

  task automatic step(input logic [W-1:0] raw, input logic [W-1:0] clr,
                      input logic [W-1:0] led);
    sw_raw  = raw;
    evt_clr = clr;
    led_in  = led;
    @(posedge clk);
    model_edge(raw, clr, led);
    #1;
    check_all();
  endtask

  // Asynchronous assert at an arbitrary point, release away from posedge.
  task automatic do_reset(input logic [W-1:0] raw, input logic [W-1:0] led);
    sw_raw  = raw;
    led_in  = led;
    evt_clr = '0;
    rst_n   = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] cur;
  int           hi_cnt;

  initial begin
    rst_n    = 1'b1;
    sw_raw   = '0;
    evt_clr  = '0;
    led_in   = '0;
    pwm_duty = 8'd64;
    model_reset();
    #2;

    // Reset with all switches high: outputs stay 0 until the debounce completes.
    do_reset(8'hFF, 8'hAA);
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF, 8'h00, 8'hAA);
      if (k < 6) chk("rst_clean_lo", sw_clean, 8'h00);
      if (k == 6) chk("rst_clean_hi", sw_clean, 8'hFF);
    end

    // Reset mid-debounce discards the pending count.
    do_reset(8'h0F, 8'h00);
    for (int k = 0; k < 4; k++) step(8'h0F, 8'h00, 8'h00);
    do_reset(8'h00, 8'h00);
    for (int k = 0; k < 6; k++) step(8'h00, 8'h00, 8'h00);
    chk("mid_rst_clean", sw_clean, 8'h00);

    // Clean step on bit 0.
    for (int k = 1; k <= 8; k++) begin
      step(8'h01, 8'h00, 8'h00);
      if (k == 5) chk("step_rise_early", sw_rise, 8'h00);
      if (k == 6) chk("step_rise", sw_rise, 8'h01);
      if (k == 7) chk("step_flag", evt_flag, 8'h01);
    end

    // Glitch on bit 3 shorter than DEB.
    for (int k = 0; k < 3; k++) step(8'h09, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) step(8'h01, 8'h00, 8'h00);
    chk("glitch_clean", sw_clean, 8'h01);
    chk("glitch_flag", evt_flag, 8'h01);

    // Flag clear colliding with a fall pulse on bit 5.
    for (int k = 0; k < 8; k++) step(8'h21, 8'h00, 8'h00);
    step(8'h21, 8'hFF, 8'h00);
    for (int k = 1; k <= 6; k++) step(8'h01, 8'h00, 8'h00);
    chk("coll_fall", sw_fall, 8'h20);
    step(8'h01, 8'h20, 8'h00);
    chk("coll_set_wins", evt_flag, 8'h20);
    step(8'h01, 8'h20, 8'h00);
    chk("coll_cleared", evt_flag, 8'h00);

    // LED path.
    step(8'h01, 8'h00, 8'h5A);
`ifndef LED_PWM_EN
    chk("led_5a", led_pad, 8'h5A);
`endif

    // Multi-bit edges.
    for (int k = 0; k < 8; k++) step(8'h00, 8'hFF, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      step(8'h81, 8'h00, 8'h00);
      if (k == 6) chk("multi_rise", sw_rise, 8'h81);
      if (k == 7) chk("multi_rise_end", sw_rise, 8'h00);
    end
    for (int k = 1; k <= 8; k++) begin
      step(8'h01, 8'h00, 8'h00);
      if (k == 6) chk("multi_fall", sw_fall, 8'h80);
    end

`ifdef LED_PWM_EN
    // Duty 64: each LED on for 64 of every 256 cycles.
    do_reset(8'h00, 8'hFF);
    for (int k = 0; k < 4; k++) step(8'h00, 8'h00, 8'hFF);
    hi_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step(8'h00, 8'h00, 8'hFF);
      if (led_pad[0]) hi_cnt++;
    end
    n_vec++;
    assert (hi_cnt == 64)
    else begin
      n_err++;
      $error("FAIL pwm_duty64: observed %0d expected 64", hi_cnt);
    end
`endif

    // Randomised phase: sparse toggles with random hold times.
    cur = 8'h01;
    for (int c = 0; c < 300; c++) begin
      int hold;
      if (c == 150) do_reset(cur, 8'h00);
      cur  = cur ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      hold = $urandom_range(1, 8);
`ifdef LED_PWM_EN
      pwm_duty = 8'($urandom);
`endif
      for (int h = 0; h < hold; h++) begin
        step(cur, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
